// File: rtl/layer_mixer.sv
// Per-pixel compositor: bullet > player > enemy > background, plus once-per-frame overlap reports and calc window.
// Latency: coordinates -> pixel_rgb/pixel_valid 2 cycles; hit pulses 1 cycle after the last visible pixel leaves.
// No backpressure: the stream advances every cycle. Collision logic present only with LAYER_MIXER_COLLISION_EN.
module layer_mixer #(
    parameter int H_ACTIVE = 1280,
    parameter int V_ACTIVE = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] display_col,
    input  logic [10:0] display_row,
    input  logic        display_valid,
    input  logic [24:0] enemy_color,
    input  logic [24:0] player_color,
    input  logic [24:0] bullet_color,
    input  logic [23:0] background_color,
    output logic [23:0] pixel_rgb,
    output logic        pixel_valid,
    output logic        calc,
    output logic        enemy_hit,
    output logic        player_hit,
    output logic [7:0]  hit_count
);

    localparam logic [11:0] COL_LAST  = 12'(H_ACTIVE - 1);
    localparam logic [10:0] ROW_LAST  = 11'(V_ACTIVE - 1);
    localparam logic [10:0] ROW_LIMIT = 11'(V_ACTIVE);

    // Stage 0: align scan position with the layer colours, which arrive one cycle later.
    logic valid_q;
    logic eof_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q <= 1'b0;
            eof_q   <= 1'b0;
        end else begin
            valid_q <= display_valid;
            eof_q   <= display_valid && (display_col == COL_LAST) && (display_row == ROW_LAST);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pixel_rgb   <= 24'd0;
            pixel_valid <= 1'b0;
        end else if (!valid_q) begin
            pixel_rgb   <= 24'd0;
            pixel_valid <= 1'b0;
        end else begin
            pixel_valid <= 1'b1;
            if (bullet_color[0])
                pixel_rgb <= bullet_color[24:1];
            else if (player_color[0])
                pixel_rgb <= player_color[24:1];
            else if (enemy_color[0])
                pixel_rgb <= enemy_color[24:1];
            else
                pixel_rgb <= background_color;
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            calc <= 1'b0;
        else
            calc <= (display_row >= ROW_LIMIT);
    end

`ifdef LAYER_MIXER_COLLISION_EN

    typedef enum logic [1:0] {
        ST_ACTIVE,
        ST_REPORT,
        ST_BLANK
    } state_t;

    state_t     state, state_d;
    logic       enemy_pend, player_pend;
    logic       enemy_pend_d, player_pend_d;
    logic       enemy_hit_d, player_hit_d;
    logic [7:0] hit_count_d;
    logic       enemy_ovl, player_ovl;

    assign enemy_ovl  = valid_q & enemy_color[0] & bullet_color[0];
    assign player_ovl = valid_q & enemy_color[0] & player_color[0];

    always_comb begin
        state_d       = state;
        enemy_pend_d  = enemy_pend;
        player_pend_d = player_pend;
        enemy_hit_d   = 1'b0;
        player_hit_d  = 1'b0;
        hit_count_d   = hit_count;
        case (state)
            ST_ACTIVE: begin
                // The final pixel's overlap is folded in before the report.
                enemy_pend_d  = enemy_pend | enemy_ovl;
                player_pend_d = player_pend | player_ovl;
                if (eof_q)
                    state_d = ST_REPORT;
            end
            ST_REPORT: begin
                enemy_hit_d   = enemy_pend;
                player_hit_d  = player_pend;
                if (enemy_pend && (hit_count != 8'hFF))
                    hit_count_d = hit_count + 8'd1;
                enemy_pend_d  = 1'b0;
                player_pend_d = 1'b0;
                state_d       = ST_BLANK;
            end
            ST_BLANK: begin
                if ((display_row == 11'd0) && (display_col == 12'd0))
                    state_d = ST_ACTIVE;
            end
            default: state_d = ST_ACTIVE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= ST_ACTIVE;
            enemy_pend  <= 1'b0;
            player_pend <= 1'b0;
            enemy_hit   <= 1'b0;
            player_hit  <= 1'b0;
            hit_count   <= 8'd0;
        end else begin
            state       <= state_d;
            enemy_pend  <= enemy_pend_d;
            player_pend <= player_pend_d;
            enemy_hit   <= enemy_hit_d;
            player_hit  <= player_hit_d;
            hit_count   <= hit_count_d;
        end
    end

`else

    assign enemy_hit  = 1'b0;
    assign player_hit = 1'b0;
    assign hit_count  = 8'd0;

    logic unused_eof;
    assign unused_eof = eof_q;

`endif

endmodule

// File: tb/tb_layer_mixer.sv
// Directed bench for layer_mixer: compositing priority, latency, calc window and per-frame hit reporting.
module tb_layer_mixer;

`ifdef LAYER_MIXER_COLLISION_EN
    localparam bit COLL = 1'b1;
`else
    localparam bit COLL = 1'b0;
`endif

    localparam logic [23:0] BG = 24'h102030;
    localparam logic [24:0] T  = 25'd0;
    localparam logic [24:0] E  = {24'hFF0000, 1'b1};
    localparam logic [24:0] P  = {24'h00FF00, 1'b1};
    localparam logic [24:0] B  = {24'h0000FF, 1'b1};

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] display_col = '0;
    logic [10:0] display_row = '0;
    logic        display_valid = 1'b0;
    logic [24:0] enemy_color = '0;
    logic [24:0] player_color = '0;
    logic [24:0] bullet_color = '0;
    logic [23:0] background_color = BG;
    logic [23:0] pixel_rgb;
    logic        pixel_valid;
    logic        calc;
    logic        enemy_hit;
    logic        player_hit;
    logic [7:0]  hit_count;

    layer_mixer dut (
        .clock            (clock),
        .reset            (reset),
        .display_col      (display_col),
        .display_row      (display_row),
        .display_valid    (display_valid),
        .enemy_color      (enemy_color),
        .player_color     (player_color),
        .bullet_color     (bullet_color),
        .background_color (background_color),
        .pixel_rgb        (pixel_rgb),
        .pixel_valid      (pixel_valid),
        .calc             (calc),
        .enemy_hit        (enemy_hit),
        .player_hit       (player_hit),
        .hit_count        (hit_count)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int errors  = 0;
    int exp_cnt = 0;

    // Expected-value delay lines, one entry per applied pixel.
    logic [23:0] rgb_p [2];
    logic        v_p   [2];
    logic        eh_p  [3];
    logic        ph_p  [3];
    logic        calc_p;
    logic [24:0] pe, pp, pb;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic clear_pipes();
        for (int i = 0; i < 2; i++) begin
            rgb_p[i] = '0;
            v_p[i]   = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            eh_p[i] = 1'b0;
            ph_p[i] = 1'b0;
        end
        calc_p = 1'b0;
        pe = T;
        pp = T;
        pb = T;
    endtask

    // One pixel per cycle: coordinates now, this pixel's layers on the next call.
    task automatic step(input logic [11:0] c, input logic [10:0] r, input logic v,
                        input logic [24:0] e, input logic [24:0] p, input logic [24:0] b,
                        input logic [23:0] xrgb, input logic xeh, input logic xph);
        @(negedge clock);
        chk("pixel_rgb", 32'(pixel_rgb), 32'(rgb_p[1]));
        chk("pixel_valid", 32'(pixel_valid), 32'(v_p[1]));
        chk("calc", 32'(calc), 32'(calc_p));
        chk("enemy_hit", 32'(enemy_hit), 32'(eh_p[2]));
        chk("player_hit", 32'(player_hit), 32'(ph_p[2]));
        rgb_p[1] = rgb_p[0];
        rgb_p[0] = xrgb;
        v_p[1]   = v_p[0];
        v_p[0]   = v;
        eh_p[2]  = eh_p[1];
        eh_p[1]  = eh_p[0];
        eh_p[0]  = COLL & xeh;
        ph_p[2]  = ph_p[1];
        ph_p[1]  = ph_p[0];
        ph_p[0]  = COLL & xph;
        calc_p   = (r >= 11'd1024);
        display_col   = c;
        display_row   = r;
        display_valid = v;
        enemy_color   = pe;
        player_color  = pp;
        bullet_color  = pb;
        pe = e;
        pp = p;
        pb = b;
    endtask

    task automatic do_reset(input int n);
        @(negedge clock);
        reset         = 1'b1;
        display_col   = '0;
        display_row   = '0;
        display_valid = 1'b0;
        enemy_color   = T;
        player_color  = T;
        bullet_color  = T;
        repeat (n) begin
            @(negedge clock);
            chk("rst_rgb", 32'(pixel_rgb), 32'h0);
            chk("rst_valid", 32'(pixel_valid), 32'h0);
            chk("rst_calc", 32'(calc), 32'h0);
            chk("rst_ehit", 32'(enemy_hit), 32'h0);
            chk("rst_phit", 32'(player_hit), 32'h0);
            chk("rst_count", 32'(hit_count), 32'h0);
        end
        reset = 1'b0;
        clear_pipes();
        exp_cnt = 0;
    endtask

    task automatic blank(input int n);
        repeat (n) step(12'd0, 11'd1024, 1'b0, T, T, T, 24'h0, 1'b0, 1'b0);
    endtask

    // kind: 0 clean, 1 enemy/bullet on last pixel, 2 enemy/player at (10,10), 3 overlap with valid low
    task automatic frame(input int kind);
        step(12'd0, 11'd0, 1'b1, T, T, T, BG, 1'b0, 1'b0);
        case (kind)
            2:       step(12'd10, 11'd10, 1'b1, E, P, T, 24'h00FF00, 1'b0, 1'b0);
            3:       step(12'd10, 11'd10, 1'b0, E, P, B, 24'h000000, 1'b0, 1'b0);
            default: step(12'd10, 11'd10, 1'b1, T, T, T, BG, 1'b0, 1'b0);
        endcase
        if (kind == 1)
            step(12'd1279, 11'd1023, 1'b1, E, T, B, 24'h0000FF, 1'b1, 1'b0);
        else
            step(12'd1279, 11'd1023, 1'b1, T, T, T, BG, 1'b0, kind == 2);
        blank(4);
        if (COLL && kind == 1 && exp_cnt < 255)
            exp_cnt++;
        chk("hit_count", 32'(hit_count), 32'(exp_cnt));
    endtask

    initial begin
        clear_pipes();
        do_reset(3);

        // Idle scan: background only, then one invalid pixel.
        step(12'd0, 11'd0, 1'b1, T, T, T, BG, 1'b0, 1'b0);
        step(12'd1, 11'd0, 1'b1, T, T, T, BG, 1'b0, 1'b0);
        step(12'd2, 11'd0, 1'b1, T, T, T, BG, 1'b0, 1'b0);
        step(12'd3, 11'd0, 1'b0, E, P, B, 24'h0, 1'b0, 1'b0);

        // Priority; these overlaps stay pending until the reset below discards them.
        step(12'd100, 11'd5, 1'b1, E, P, B, 24'h0000FF, 1'b0, 1'b0);
        step(12'd101, 11'd5, 1'b1, E, P, T, 24'h00FF00, 1'b0, 1'b0);
        step(12'd102, 11'd5, 1'b1, E, T, T, 24'hFF0000, 1'b0, 1'b0);
        step(12'd103, 11'd5, 1'b1, T, T, T, BG, 1'b0, 1'b0);
        step(12'd104, 11'd5, 1'b1, T, T, T, BG, 1'b0, 1'b0);
        do_reset(2);
        step(12'd1279, 11'd1023, 1'b1, T, T, T, BG, 1'b0, 1'b0);
        blank(4);
        chk("count_after_reset", 32'(hit_count), 32'h0);

        frame(1);
        frame(0);
        frame(2);
        frame(2);
        frame(3);
        repeat (300) frame(1);
        chk("count_saturated", 32'(hit_count), COLL ? 32'd255 : 32'd0);

        // calc window around the bottom of the visible area.
        step(12'd0, 11'd1023, 1'b0, T, T, T, 24'h0, 1'b0, 1'b0);
        step(12'd0, 11'd1024, 1'b0, T, T, T, 24'h0, 1'b0, 1'b0);
        step(12'd0, 11'd1065, 1'b0, T, T, T, 24'h0, 1'b0, 1'b0);
        step(12'd0, 11'd0, 1'b0, T, T, T, 24'h0, 1'b0, 1'b0);
        step(12'd0, 11'd0, 1'b0, T, T, T, 24'h0, 1'b0, 1'b0);
        step(12'd0, 11'd0, 1'b0, T, T, T, 24'h0, 1'b0, 1'b0);
        step(12'd0, 11'd0, 1'b0, T, T, T, 24'h0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
